switch_scheduler: RTL
=====================

Name: switch_scheduler

Overview:
Central crossbar scheduler for the 4-port switch. It sits between the NUM_PORTS per-input-port packet FIFOs and the NUM_PORTS output ports. It inspects each non-empty FIFO's head header and runs one round-robin arbiter per output port. It holds each grant for a whole packet, drives the FIFO read enables, and steers the read data to the destination output with valid/sop/eop framing.

Parameters:
NUM_PORTS, 4, number of input FIFOs and output ports (power of 2, >=2)
DATA_WIDTH, 16, FIFO word width; header is low DATA_WIDTH/2 bits
PTR_W, $clog2(NUM_PORTS), port index width (derived localparam)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  NUM_PORTS  per-input FIFO empty flag
fifo_header  input  NUM_PORTS*DATA_WIDTH/2  per-input head-word header, input i at slice i
fifo_data  input  NUM_PORTS*DATA_WIDTH  per-input registered FIFO read data, slice i
fifo_rd_en  output  NUM_PORTS  per-input FIFO read enable
out_ready  input  NUM_PORTS  per-output: downstream has >=2 free entries
out_valid  output  NUM_PORTS  per-output word valid
out_data  output  NUM_PORTS*DATA_WIDTH  per-output data, slice o
out_sop  output  NUM_PORTS  first word (header) of packet
out_eop  output  NUM_PORTS  last word of packet
in_busy  output  NUM_PORTS  input i currently owned by some output

Behaviour:
- Header fields: dst = hdr[PTR_W-1:0]; len = hdr[7:4] = payload words after the header (0..15). A packet is len+1 words.
- Reset (async, rst_n=0): all outputs 0; every output FSM in IDLE; rr pointer = NUM_PORTS-1 (so input 0 wins first); in_busy=0. Reset mid-packet abandons the packet with no eop.
- req[i][o] = !fifo_empty[i] && !in_busy[i] && dst(i)==o. Each header names one output, so an input cannot be granted twice in one cycle.
- Per-output FSM:
  - IDLE: if any req[*][o] is set, pick the first requester searching upward from rr_ptr[o]+1 with wrap. Register owner[o]=i, rr_ptr[o]=i, remaining[o]=len+1 (5 bits), set in_busy[i], then go to XFER. The grant cycle issues no read.
  - XFER: fifo_rd_en[owner] = out_ready[o] && !fifo_empty[owner] && remaining!=0. Each read decrements remaining. On the read with remaining==1, go to IDLE next cycle and clear in_busy[owner] at that same edge. If the FIFO is empty mid-packet, stall in XFER with no rd_en. No timeout.
- Datapath latency: the FIFO registers data on rd_en, so out_valid[o] = rd_en issued at the previous cycle for o. out_data[o] = fifo_data[owner_d] where owner_d is owner delayed one cycle. out_sop marks the first read of a grant and out_eop the read that took remaining to 0, both delayed one cycle alongside valid.
- Throughput: 1 word/cycle per output while ready. Minimum gap between packets on one output is 1 idle cycle (the grant cycle). All outputs operate concurrently and independently.
- Backpressure: out_ready is sampled on the rd_en cycle. Downstream must accept the word that arrives one cycle later, which is why out_ready needs >=2 free entries.
- While an input is busy, its header bits show payload. They must be ignored, and in_busy gating guarantees this.
- remaining never underflows; rd_en is never asserted to an empty FIFO.
- out_data is 0 when out_valid=0.

Test Plan:
- Single packet: reset, input 2 holds header dst=1 len=3 followed by 3 payload words. Required: grant after 1 cycle, rd_en[2] high for 4 consecutive cycles; out_valid[1] for 4 cycles starting 1 cycle later; sop on word0, eop on word3; output 1 returns to IDLE.
- Round-robin: inputs 0, 1, 3 each hold a len=0 packet to output 2. Required service order is 0, 1, 3, then 0 again on the next round, with 1 idle cycle between packets.
- Concurrency: input0→out3 len=2 and input1→out0 len=2 simultaneously. Both outputs stream in the same cycles with no interference; in_busy=0011 during the transfer.
- Backpressure/underrun: drop out_ready for 3 cycles mid-packet, then empty the source FIFO for 2 cycles. rd_en must drop both times; no word may be lost or duplicated; eop still lands on word len+1.
- Busy masking: input 0 mid-packet has payload low bits encoding dst=2 while output 2 is idle. Output 2 must not grant input 0.
- Reset mid-packet: assert rst_n=0 during XFER. Required: all outputs, rd_en and in_busy are 0 immediately; after release, the first request granted is input 0.

Source files
------------

// File: rtl/switch_scheduler.sv
// Crossbar scheduler: one round-robin arbiter and packet-length FSM per output.
// Each grant is held for a whole packet; FIFO read data is steered to the output one cycle later.
module switch_scheduler #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              fifo_empty,
    input  logic [NUM_PORTS*DATA_WIDTH/2-1:0] fifo_header,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   fifo_data,
    output logic [NUM_PORTS-1:0]              fifo_rd_en,
    input  logic [NUM_PORTS-1:0]              out_ready,
    output logic [NUM_PORTS-1:0]              out_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   out_data,
    output logic [NUM_PORTS-1:0]              out_sop,
    output logic [NUM_PORTS-1:0]              out_eop,
    output logic [NUM_PORTS-1:0]              in_busy
);
    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int HDR_W = DATA_WIDTH / 2;

    typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

    state_t               state_q     [NUM_PORTS];
    state_t               state_d     [NUM_PORTS];
    logic [PTR_W-1:0]     owner_q     [NUM_PORTS];
    logic [PTR_W-1:0]     owner_d     [NUM_PORTS];
    logic [PTR_W-1:0]     rr_q        [NUM_PORTS];
    logic [PTR_W-1:0]     rr_d        [NUM_PORTS];
    logic [4:0]           rem_q       [NUM_PORTS];
    logic [4:0]           rem_d       [NUM_PORTS];
    logic [PTR_W-1:0]     owner_dly_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] first_q, first_d;
    logic [NUM_PORTS-1:0] busy_q, busy_d;
    logic [NUM_PORTS-1:0] valid_q, sop_q, eop_q;
    logic [NUM_PORTS-1:0] rd_s;
    logic [PTR_W-1:0]     dst_s       [NUM_PORTS];
    logic [3:0]           len_s       [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_s       [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_mask_s   [NUM_PORTS];
    logic                 found_s;
    logic [PTR_W-1:0]     pick_s, cand_s;
    logic                 hdr_unused_s;

    assign hdr_unused_s = ^fifo_header;

    // Header decode and request matrix; busy inputs are masked because their head word is payload
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            dst_s[i] = fifo_header[i*HDR_W +: PTR_W];
            len_s[i] = fifo_header[i*HDR_W+4 +: 4];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_s[o][i] = !fifo_empty[i] && !busy_q[i] && (dst_s[i] == PTR_W'(o));
            end
        end
    end

    // Per-output arbitration and packet FSM next state
    always_comb begin
        busy_d  = busy_q;
        first_d = first_q;
        rd_s    = '0;
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            rem_d[o]   = rem_q[o];
            case (state_q[o])
                S_IDLE: begin
                    found_s = 1'b0;
                    pick_s  = '0;
                    for (int k = 1; k <= NUM_PORTS; k++) begin
                        cand_s = rr_q[o] + PTR_W'(k);
                        if (!found_s && req_s[o][cand_s]) begin
                            found_s = 1'b1;
                            pick_s  = cand_s;
                        end else begin
                            found_s = found_s;
                        end
                    end
                    if (found_s) begin
                        owner_d[o]     = pick_s;
                        rr_d[o]        = pick_s;
                        rem_d[o]       = {1'b0, len_s[pick_s]} + 5'd1;
                        first_d[o]     = 1'b1;
                        busy_d[pick_s] = 1'b1;
                        state_d[o]     = S_XFER;
                    end else begin
                        state_d[o] = S_IDLE;
                    end
                end
                S_XFER: begin
                    rd_s[o] = out_ready[o] && !fifo_empty[owner_q[o]] && (rem_q[o] != 5'd0);
                    if (rd_s[o]) begin
                        rem_d[o]   = rem_q[o] - 5'd1;
                        first_d[o] = 1'b0;
                        if (rem_q[o] == 5'd1) begin
                            state_d[o]         = S_IDLE;
                            busy_d[owner_q[o]] = 1'b0;
                        end else begin
                            state_d[o] = S_XFER;
                        end
                    end else begin
                        state_d[o] = S_XFER;
                    end
                end
                default: state_d[o] = S_IDLE;
            endcase
        end
    end

    // Route each output's read strobe back to the input it owns
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                rd_mask_s[i][o] = rd_s[o] && (owner_q[o] == PTR_W'(i));
            end
            fifo_rd_en[i] = |rd_mask_s[i];
        end
    end

    // State registers; framing is delayed one cycle to line up with the FIFO's registered data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o]     <= S_IDLE;
                owner_q[o]     <= '0;
                rr_q[o]        <= PTR_W'(NUM_PORTS - 1);
                rem_q[o]       <= 5'd0;
                owner_dly_q[o] <= '0;
            end
            first_q <= '0;
            busy_q  <= '0;
            valid_q <= '0;
            sop_q   <= '0;
            eop_q   <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o]     <= state_d[o];
                owner_q[o]     <= owner_d[o];
                rr_q[o]        <= rr_d[o];
                rem_q[o]       <= rem_d[o];
                owner_dly_q[o] <= owner_q[o];
                sop_q[o]       <= rd_s[o] && first_q[o];
                eop_q[o]       <= rd_s[o] && (rem_q[o] == 5'd1);
            end
            first_q <= first_d;
            busy_q  <= busy_d;
            valid_q <= rd_s;
        end
    end

    // Output data mux, forced to zero when no word is presented
    always_comb begin
        out_data = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (valid_q[o]) begin
                out_data[o*DATA_WIDTH +: DATA_WIDTH] =
                    fifo_data[int'(owner_dly_q[o])*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                out_data[o*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign in_busy   = busy_q;
endmodule
